// File: rtl/ssd1306_spi_tx_if.sv
// Byte handshake between the SSD1306 microcode executor (master) and the
// SPI byte transmitter (slave).
interface ssd1306_spi_tx_if;
  logic       spi_tx_trigger_in;
  logic [7:0] spi_data_in;
  logic       spi_last_byte_in;
  logic       spi_ready_out;

  modport master (
    output spi_tx_trigger_in,
    output spi_data_in,
    output spi_last_byte_in,
    input  spi_ready_out
  );

  modport slave (
    input  spi_tx_trigger_in,
    input  spi_data_in,
    input  spi_last_byte_in,
    output spi_ready_out
  );
endinterface

// File: rtl/ssd1306_spi_tx.sv
// SPI mode-0 byte transmitter for the SSD1306: MSB-first serialisation with
// CSn held low across a burst and released with hold/gap timing after the last byte.
module ssd1306_spi_tx #(
  parameter int unsigned CLK_DIV         = 2,
  parameter int unsigned CS_SETUP_CYCLES = 2,
  parameter int unsigned CS_HOLD_CYCLES  = 2,
  parameter int unsigned CS_GAP_CYCLES   = 4
) (
  input  logic                   clk_in,
  input  logic                   reset_in,
  ssd1306_spi_tx_if.slave        spi_if,
  output logic                   oled_sclk_out,
  output logic                   oled_sdin_out,
  output logic                   oled_csn_out,
  output logic                   burst_done_out
);

  localparam int unsigned MAX_A   = (CLK_DIV > CS_SETUP_CYCLES) ? CLK_DIV : CS_SETUP_CYCLES;
  localparam int unsigned MAX_B   = (CS_HOLD_CYCLES > CS_GAP_CYCLES) ? CS_HOLD_CYCLES : CS_GAP_CYCLES;
  localparam int unsigned CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CS_SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(CS_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(CS_GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_CS_SETUP  = 3'd1,
    S_SHIFT     = 3'd2,
    S_WAIT_NEXT = 3'd3,
    S_CS_HOLD   = 3'd4,
    S_CS_GAP    = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             last_q, last_d;
  logic             sclk_q, sclk_d;
  logic             sdin_q, sdin_d;
  logic             csn_q, csn_d;
  logic             done_q, done_d;
  logic             ready_q, ready_d;
  logic             accept_s;

  // Next-state and next-output computation for the transmit sequencer.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    last_d    = last_q;
    sclk_d    = sclk_q;
    sdin_d    = sdin_q;
    csn_d     = csn_q;
    done_d    = 1'b0;
    accept_s  = ready_q & spi_if.spi_tx_trigger_in;

    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          shift_d   = spi_if.spi_data_in;
          last_d    = spi_if.spi_last_byte_in;
          bit_idx_d = 3'd7;
          sdin_d    = spi_if.spi_data_in[7];
          sclk_d    = 1'b0;
          csn_d     = 1'b0;
          cnt_d     = CNT_ZERO;
          state_d   = S_CS_SETUP;
        end else begin
          csn_d  = 1'b1;
          sclk_d = 1'b0;
        end
      end
      S_CS_SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          cnt_d   = CNT_ZERO;
          state_d = S_SHIFT;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_SHIFT: begin
        // Each phase lasts CLK_DIV cycles; data only moves on the falling side.
        if (cnt_q == DIV_LAST) begin
          cnt_d = CNT_ZERO;
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else begin
            sclk_d = 1'b0;
            if (bit_idx_q == 3'd0) begin
              state_d = last_q ? S_CS_HOLD : S_WAIT_NEXT;
            end else begin
              bit_idx_d = bit_idx_q - 3'd1;
              sdin_d    = shift_q[bit_idx_q - 3'd1];
            end
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_WAIT_NEXT: begin
        if (accept_s) begin
          shift_d   = spi_if.spi_data_in;
          last_d    = spi_if.spi_last_byte_in;
          bit_idx_d = 3'd7;
          sdin_d    = spi_if.spi_data_in[7];
          cnt_d     = CNT_ZERO;
          state_d   = S_SHIFT;
        end else begin
          sclk_d = 1'b0;
        end
      end
      S_CS_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          cnt_d   = CNT_ZERO;
          csn_d   = 1'b1;
          done_d  = 1'b1;
          state_d = S_CS_GAP;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_CS_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = CNT_ZERO;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = CNT_ZERO;
        csn_d   = 1'b1;
        sclk_d  = 1'b0;
      end
    endcase

    // Registered copy of the ready decode, so it is valid the cycle the state is.
    ready_d = (state_d == S_IDLE) || (state_d == S_WAIT_NEXT);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_q   <= S_IDLE;
      cnt_q     <= CNT_ZERO;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'h00;
      last_q    <= 1'b0;
      sclk_q    <= 1'b0;
      sdin_q    <= 1'b0;
      csn_q     <= 1'b1;
      done_q    <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      last_q    <= last_d;
      sclk_q    <= sclk_d;
      sdin_q    <= sdin_d;
      csn_q     <= csn_d;
      done_q    <= done_d;
      ready_q   <= ready_d;
    end
  end

  assign spi_if.spi_ready_out = ready_q;
  assign oled_sclk_out        = sclk_q;
  assign oled_sdin_out        = sdin_q;
  assign oled_csn_out         = csn_q;
  assign burst_done_out       = done_q;

endmodule

// File: tb/tb_ssd1306_spi_tx.sv
// Directed bench for ssd1306_spi_tx: default-parameter instance plus a CLK_DIV=1 instance.
module tb_ssd1306_spi_tx;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ssd1306_spi_tx_if if_a ();
  ssd1306_spi_tx_if if_b ();

  logic sclk_a, sdin_a, csn_a, done_a;
  logic sclk_b, sdin_b, csn_b, done_b;

  ssd1306_spi_tx dut_a (
    .clk_in         (clk),
    .reset_in       (rst),
    .spi_if         (if_a.slave),
    .oled_sclk_out  (sclk_a),
    .oled_sdin_out  (sdin_a),
    .oled_csn_out   (csn_a),
    .burst_done_out (done_a)
  );

  ssd1306_spi_tx #(.CLK_DIV(1)) dut_b (
    .clk_in         (clk),
    .reset_in       (rst),
    .spi_if         (if_b.slave),
    .oled_sclk_out  (sclk_b),
    .oled_sdin_out  (sdin_b),
    .oled_csn_out   (csn_b),
    .burst_done_out (done_b)
  );

  int checks = 0;
  int failures = 0;

  // Line monitors sampled on the falling clock edge.
  int rises_a = 0, dones_a = 0, csn_rises_a = 0, unstable_a = 0;
  logic [31:0] bits_a = 32'h0;
  logic prev_sclk_a = 1'b0, prev_sdin_a = 1'b0, prev_csn_a = 1'b1;
  int rises_b = 0, unstable_b = 0;
  logic [31:0] bits_b = 32'h0;
  logic prev_sclk_b = 1'b0, prev_sdin_b = 1'b0;

  always @(negedge clk) begin
    if (sclk_a === 1'b1 && prev_sclk_a === 1'b0) begin
      rises_a++;
      bits_a = {bits_a[30:0], sdin_a};
      if (sdin_a !== prev_sdin_a) unstable_a++;
    end
    if (sclk_a === 1'b1 && prev_sclk_a === 1'b1 && sdin_a !== prev_sdin_a) unstable_a++;
    if (done_a === 1'b1) dones_a++;
    if (csn_a === 1'b1 && prev_csn_a === 1'b0) csn_rises_a++;
    prev_sclk_a = sclk_a;
    prev_sdin_a = sdin_a;
    prev_csn_a  = csn_a;
    if (sclk_b === 1'b1 && prev_sclk_b === 1'b0) begin
      rises_b++;
      bits_b = {bits_b[30:0], sdin_b};
      if (sdin_b !== prev_sdin_b) unstable_b++;
    end
    if (sclk_b === 1'b1 && prev_sclk_b === 1'b1 && sdin_b !== prev_sdin_b) unstable_b++;
    prev_sclk_b = sclk_b;
    prev_sdin_b = sdin_b;
  end

  task automatic clear_mon();
    rises_a = 0; dones_a = 0; csn_rises_a = 0; unstable_a = 0; bits_a = 32'h0;
    rises_b = 0; unstable_b = 0; bits_b = 32'h0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits for ready, hands one byte to DUT A, returns cycles from accept to first SCLK high.
  task automatic send_byte(input logic [7:0] data, input logic last, output int lat);
    int n;
    n = 0;
    while (if_a.spi_ready_out !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    lat = -1;
    if (if_a.spi_ready_out === 1'b1) begin
      if_a.spi_data_in       = data;
      if_a.spi_last_byte_in  = last;
      if_a.spi_tx_trigger_in = 1'b1;
      step();
      if_a.spi_tx_trigger_in = 1'b0;
      n = 1;
      while (sclk_a !== 1'b1 && n < 100) begin
        step();
        n++;
      end
      if (sclk_a === 1'b1) lat = n;
    end
  endtask

  task automatic wait_idle(output bit ok);
    int n;
    n = 0;
    while (!(if_a.spi_ready_out === 1'b1 && csn_a === 1'b1) && n < 300) begin
      step();
      n++;
    end
    ok = (if_a.spi_ready_out === 1'b1 && csn_a === 1'b1);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    if_a.spi_tx_trigger_in = 1'b0; if_a.spi_data_in = 8'h00; if_a.spi_last_byte_in = 1'b0;
    if_b.spi_tx_trigger_in = 1'b0; if_b.spi_data_in = 8'h00; if_b.spi_last_byte_in = 1'b0;
    repeat (3) step();
    if_a.spi_tx_trigger_in = 1'b1;
    step();
    checks++; if (csn_a !== 1'b1) begin failures++; $display("FAIL reset_csn got=%b exp=1", csn_a); end
    checks++; if (sclk_a !== 1'b0) begin failures++; $display("FAIL reset_sclk got=%b exp=0", sclk_a); end
    checks++; if (sdin_a !== 1'b0) begin failures++; $display("FAIL reset_sdin got=%b exp=0", sdin_a); end
    checks++; if (done_a !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done_a); end
    checks++; if (if_a.spi_ready_out !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", if_a.spi_ready_out); end
    if_a.spi_tx_trigger_in = 1'b0;
    rst = 1'b0;
    step();
    checks++; if (csn_a !== 1'b1) begin failures++; $display("FAIL reset_trigger_ignored csn got=%b exp=1", csn_a); end
  endtask

  task automatic test_single_byte();
    int first_rise, csn_rise_c, done_c, ready_c;
    first_rise = 0; csn_rise_c = 0; done_c = 0; ready_c = 0;
    clear_mon();
    if_a.spi_data_in = 8'hA5; if_a.spi_last_byte_in = 1'b1; if_a.spi_tx_trigger_in = 1'b1;
    step();
    if_a.spi_tx_trigger_in = 1'b0;
    checks++; if (csn_a !== 1'b0) begin failures++; $display("FAIL single_csn_fall got=%b exp=0", csn_a); end
    checks++; if (if_a.spi_ready_out !== 1'b0) begin failures++; $display("FAIL single_ready_drop got=%b exp=0", if_a.spi_ready_out); end
    checks++; if (sdin_a !== 1'b1) begin failures++; $display("FAIL single_sdin_msb got=%b exp=1", sdin_a); end
    for (int c = 1; c <= 60; c++) begin
      if (sclk_a === 1'b1 && first_rise == 0) first_rise = c;
      if (csn_a === 1'b1 && csn_rise_c == 0) csn_rise_c = c;
      if (done_a === 1'b1 && done_c == 0) done_c = c;
      if (if_a.spi_ready_out === 1'b1 && ready_c == 0) ready_c = c;
      step();
    end
    checks++; if (first_rise != 5) begin failures++; $display("FAIL single_first_rise got=%0d exp=5", first_rise); end
    checks++; if (csn_rise_c != 37) begin failures++; $display("FAIL single_csn_rise got=%0d exp=37", csn_rise_c); end
    checks++; if (done_c != 37) begin failures++; $display("FAIL single_done_cycle got=%0d exp=37", done_c); end
    checks++; if (ready_c != 41) begin failures++; $display("FAIL single_ready_return got=%0d exp=41", ready_c); end
    checks++; if (rises_a != 8) begin failures++; $display("FAIL single_rises got=%0d exp=8", rises_a); end
    checks++; if (bits_a[7:0] !== 8'hA5) begin failures++; $display("FAIL single_bits got=%h exp=a5", bits_a[7:0]); end
    checks++; if (dones_a != 1) begin failures++; $display("FAIL single_done_count got=%0d exp=1", dones_a); end
    checks++; if (unstable_a != 0) begin failures++; $display("FAIL single_sdin_stable got=%0d exp=0", unstable_a); end
  endtask

  task automatic test_back_to_back();
    int lat1, lat2, lat3;
    bit ok;
    clear_mon();
    send_byte(8'h81, 1'b0, lat1);
    send_byte(8'h3C, 1'b0, lat2);
    send_byte(8'hFF, 1'b1, lat3);
    wait_idle(ok);
    checks++; if (!ok) begin failures++; $display("FAIL burst_idle_timeout got=%b exp=1", ok); end
    checks++; if (lat1 != 5) begin failures++; $display("FAIL burst_lat_first got=%0d exp=5", lat1); end
    checks++; if (lat2 != 3) begin failures++; $display("FAIL burst_lat_second got=%0d exp=3", lat2); end
    checks++; if (lat3 != 3) begin failures++; $display("FAIL burst_lat_third got=%0d exp=3", lat3); end
    checks++; if (rises_a != 24) begin failures++; $display("FAIL burst_rises got=%0d exp=24", rises_a); end
    checks++; if (bits_a[23:0] !== 24'h813CFF) begin failures++; $display("FAIL burst_bits got=%h exp=813cff", bits_a[23:0]); end
    checks++; if (csn_rises_a != 1) begin failures++; $display("FAIL burst_csn_rises got=%0d exp=1", csn_rises_a); end
    checks++; if (dones_a != 1) begin failures++; $display("FAIL burst_done_count got=%0d exp=1", dones_a); end
  endtask

  task automatic test_held_trigger();
    int lat;
    bit ok;
    clear_mon();
    if_a.spi_data_in = 8'h55; if_a.spi_last_byte_in = 1'b1; if_a.spi_tx_trigger_in = 1'b1;
    repeat (40) step();
    if_a.spi_tx_trigger_in = 1'b0;
    checks++; if (if_a.spi_ready_out !== 1'b0) begin failures++; $display("FAIL held_ready_in_gap got=%b exp=0", if_a.spi_ready_out); end
    step();
    checks++; if (if_a.spi_ready_out !== 1'b1) begin failures++; $display("FAIL held_ready_after_gap got=%b exp=1", if_a.spi_ready_out); end
    checks++; if (csn_a !== 1'b1) begin failures++; $display("FAIL held_no_reaccept got=%b exp=1", csn_a); end
    checks++; if (rises_a != 8) begin failures++; $display("FAIL held_rises got=%0d exp=8", rises_a); end
    checks++; if (bits_a[7:0] !== 8'h55) begin failures++; $display("FAIL held_bits got=%h exp=55", bits_a[7:0]); end
    checks++; if (dones_a != 1) begin failures++; $display("FAIL held_done_count got=%0d exp=1", dones_a); end
    send_byte(8'h55, 1'b1, lat);
    wait_idle(ok);
    checks++; if (lat != 5 || !ok) begin failures++; $display("FAIL held_second_accept got=%0d exp=5", lat); end
  endtask

  task automatic test_clk_div1();
    int first_rise, toggles, highs, csn_rise_c;
    logic prev;
    first_rise = 0; toggles = 0; highs = 0; csn_rise_c = 0; prev = 1'b0;
    clear_mon();
    if_b.spi_data_in = 8'h0F; if_b.spi_last_byte_in = 1'b1; if_b.spi_tx_trigger_in = 1'b1;
    step();
    if_b.spi_tx_trigger_in = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      if (sclk_b === 1'b1 && first_rise == 0) first_rise = c;
      if (sclk_b !== prev) toggles++;
      if (sclk_b === 1'b1) highs++;
      if (csn_b === 1'b1 && csn_rise_c == 0) csn_rise_c = c;
      prev = sclk_b;
      step();
    end
    checks++; if (first_rise != 4) begin failures++; $display("FAIL div1_first_rise got=%0d exp=4", first_rise); end
    checks++; if (toggles != 16) begin failures++; $display("FAIL div1_toggles got=%0d exp=16", toggles); end
    checks++; if (highs != 8) begin failures++; $display("FAIL div1_high_cycles got=%0d exp=8", highs); end
    checks++; if (csn_rise_c != 21) begin failures++; $display("FAIL div1_csn_rise got=%0d exp=21", csn_rise_c); end
    checks++; if (bits_b[7:0] !== 8'h0F) begin failures++; $display("FAIL div1_bits got=%h exp=0f", bits_b[7:0]); end
    checks++; if (unstable_b != 0) begin failures++; $display("FAIL div1_sdin_stable got=%0d exp=0", unstable_b); end
  endtask

  task automatic test_reset_mid_byte();
    int lat, n;
    bit ok;
    clear_mon();
    send_byte(8'h5A, 1'b1, lat);
    n = 0;
    while (rises_a < 3 && n < 50) begin
      step();
      n++;
    end
    checks++; if (rises_a != 3) begin failures++; $display("FAIL midrst_reach_third got=%0d exp=3", rises_a); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (csn_a !== 1'b1) begin failures++; $display("FAIL midrst_csn got=%b exp=1", csn_a); end
    checks++; if (sclk_a !== 1'b0) begin failures++; $display("FAIL midrst_sclk got=%b exp=0", sclk_a); end
    checks++; if (if_a.spi_ready_out !== 1'b1) begin failures++; $display("FAIL midrst_ready got=%b exp=1", if_a.spi_ready_out); end
    repeat (10) step();
    checks++; if (dones_a != 0) begin failures++; $display("FAIL midrst_no_done got=%0d exp=0", dones_a); end
    clear_mon();
    send_byte(8'h12, 1'b1, lat);
    wait_idle(ok);
    checks++; if (bits_a[7:0] !== 8'h12 || rises_a != 8) begin failures++; $display("FAIL midrst_next_byte got=%h/%0d exp=12/8", bits_a[7:0], rises_a); end
    checks++; if (dones_a != 1 || !ok) begin failures++; $display("FAIL midrst_next_done got=%0d exp=1", dones_a); end
  endtask

  task automatic test_wait_next_idle();
    int lat, n, viol;
    bit ok;
    clear_mon();
    send_byte(8'h81, 1'b0, lat);
    n = 0;
    while (if_a.spi_ready_out !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    viol = 0;
    for (int c = 0; c < 100; c++) begin
      if (csn_a !== 1'b0 || sclk_a !== 1'b0 || if_a.spi_ready_out !== 1'b1) viol++;
      step();
    end
    checks++; if (viol != 0) begin failures++; $display("FAIL waitnext_hold got=%0d exp=0", viol); end
    send_byte(8'hC3, 1'b1, lat);
    wait_idle(ok);
    checks++; if (lat != 3 || !ok) begin failures++; $display("FAIL waitnext_resume_lat got=%0d exp=3", lat); end
    checks++; if (bits_a[15:0] !== 16'h81C3 || rises_a != 16) begin failures++; $display("FAIL waitnext_bits got=%h/%0d exp=81c3/16", bits_a[15:0], rises_a); end
    checks++; if (dones_a != 1) begin failures++; $display("FAIL waitnext_done got=%0d exp=1", dones_a); end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_held_trigger();
    test_clk_div1();
    test_reset_mid_byte();
    test_wait_next_idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
